descriptor_ram_dp: RTL and testbench
====================================

# descriptor_ram_dp

- Parametrised dual-port on-chip descriptor store for scatter-gather DMA descriptor chains.
- Two independent Avalon-MM slaves share one RAM with byte enables: s1 faces the CPU, s2 faces the DMA engine.
- Adds configurable width and depth, fixed read latency with `readdatavalid`, defined write-collision resolution, out-of-range guarding and a saturating collision counter.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; a multiple of 8.
- ADDR_WIDTH, 10, word-address width.
- DEPTH, 1024, number of words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- CNT_WIDTH, 16, width of `collision_count`.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- clken  in  1  global clock enable; 0 freezes all state.
- s1_address / s2_address  in  ADDR_WIDTH  word address.
- s1_chipselect / s2_chipselect  in  1  slave select.
- s1_read / s2_read  in  1  read request.
- s1_write / s2_write  in  1  write request.
- s1_byteenable / s2_byteenable  in  DATA_WIDTH/8  byte lane enables.
- s1_writedata / s2_writedata  in  DATA_WIDTH  write data.
- s1_readdata / s2_readdata  out  DATA_WIDTH  read data.
- s1_readdatavalid / s2_readdatavalid  out  1  one-cycle strobe marking valid readdata.
- oor_error  out  1  sticky flag: an access targeted an address ≥ DEPTH.
- collision_count  out  CNT_WIDTH  count of same-address dual writes; saturates.

## Operation
- Write occurs when chipselect & write & clken. Enabled bytes are stored at the rising edge of cycle N. Reads issued at N+1 or later see the new data.
- Read occurs when chipselect & read & write=0 & clken. If read and write are both asserted on one port, the access is a write only and no `readdatavalid` is produced.
- No waitrequest: every port accepts one access per enabled cycle.
- Mixed-port read/write to the same address in the same cycle: the read returns the old contents (read-before-write).
- Dual write to the same address in the same cycle:
  - Per byte lane, s1 wins where both ports enable the lane.
  - s2 lanes apply where only s2 enables them.
  - `collision_count` increments by 1 and stops at 2^CNT_WIDTH−1.
- Out-of-range address (≥ DEPTH):
  - Writes are dropped.
  - Reads return all-zero data with `readdatavalid` asserted.
  - `oor_error` is set and stays set until reset.
- clken=0:
  - No memory access is launched.
  - The read pipeline, readdata, readdatavalid, the counter and the flag all hold their values.
  - Requests presented during clken=0 are ignored, not queued.
- Reset:
  - readdata = 0, readdatavalid = 0, oor_error = 0, collision_count = 0.
  - In-flight reads are discarded.
  - RAM contents are NOT cleared.

## Timing
- Read latency L is counted in enabled cycles from request to the `readdatavalid` strobe. L = 1 by default; L = 2 with the output register (see Configuration).
- `readdatavalid` is high for exactly one enabled cycle per accepted read. Back-to-back reads give back-to-back strobes, and responses come back in request order.
- readdata holds the last returned value between strobes.
- Reset assertion takes effect immediately on the outputs, independent of clk. The first access is accepted in the first cycle after reset deasserts.
- `collision_count` and `oor_error` update one cycle after the offending request.

## Configuration
- Macro: `DESCRIPTOR_RAM_DP_OUTREG_EN`.
- Defined:
  - A register is inserted after the RAM output on both ports, so L = 2 and readdatavalid is delayed by one stage.
  - The output register is also cleared by reset and frozen by clken.
- Undefined:
  - RAM q drives readdata directly through a valid-qualified holding register, so L = 1.

## Test plan
- s1 writes 0xDEADBEEF to addr 5 with be=0xF. s2 reads addr 5 next cycle → s2_readdata = 0xDEADBEEF and s2_readdatavalid high exactly L cycles after the read.
- s1 writes 0x11223344 to addr 7 with be=0xF. Then, in one cycle, s1 writes 0xAAAAAAAA with be=0x3 and s2 writes 0xBBBBBBBB with be=0x6 to addr 7 → addr 7 reads 0x11BBAAAA and collision_count = 1.
- s2 writes addr 9 with 0x55 while s1 reads addr 9 (old value 0) in the same cycle → s1 gets 0. A following s1 read of addr 9 returns 0x55.
- With DEPTH=1000, s1 writes addr 1000 and then reads it → the read returns 0 with valid, oor_error = 1, and addr 1000 mod DEPTH is not modified.
- Issue 4 back-to-back s2 reads (addr 0–3) and drop clken for 2 cycles mid-stream → 4 strobes in order and no strobe while clken = 0. Assert reset with 2 reads in flight → no strobes after reset, and all outputs 0 immediately.
- Force 2^CNT_WIDTH+3 dual same-address writes (CNT_WIDTH=4) → collision_count saturates at 15.

Source files
------------

// File: rtl/descriptor_ram_dp.sv
// descriptor_ram_dp: dual-port Avalon-MM descriptor store with byte enables, s1 priority on dual writes.
// Define DESCRIPTOR_RAM_DP_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module descriptor_ram_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    oor_error,
    output logic [CNT_WIDTH-1:0]    collision_count
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic s1_wr, s1_rd, s1_inr;
    logic s2_wr, s2_rd, s2_inr;

    assign s1_wr  = clken & s1_chipselect & s1_write;
    assign s1_rd  = clken & s1_chipselect & s1_read & ~s1_write;
    assign s1_inr = {1'b0, s1_address} < DEPTH_W;
    assign s2_wr  = clken & s2_chipselect & s2_write;
    assign s2_rd  = clken & s2_chipselect & s2_read & ~s2_write;
    assign s2_inr = {1'b0, s2_address} < DEPTH_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // s2 lanes are scheduled first so s1 overrides them where both ports enable a lane
    always_ff @(posedge clk) begin
        if (s2_wr && s2_inr) begin
            for (int b = 0; b < NB; b++) begin
                if (s2_byteenable[b]) mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
            end
        end
        if (s1_wr && s1_inr) begin
            for (int b = 0; b < NB; b++) begin
                if (s1_byteenable[b]) mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
            end
        end
    end

    logic                  rd1_vld_q, rd2_vld_q;
    logic [DATA_WIDTH-1:0] rd1_data_q, rd2_data_q;

    // Data registers only load on an accepted read, so they hold the last response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_vld_q  <= 1'b0;
            rd2_vld_q  <= 1'b0;
            rd1_data_q <= '0;
            rd2_data_q <= '0;
        end else if (clken) begin
            rd1_vld_q <= s1_rd;
            rd2_vld_q <= s2_rd;
            if (s1_rd) rd1_data_q <= s1_inr ? mem[s1_address] : '0;
            if (s2_rd) rd2_data_q <= s2_inr ? mem[s2_address] : '0;
        end
    end

    logic                 oor_q, oor_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        oor_d = oor_q;
        cnt_d = cnt_q;
        if (((s1_wr | s1_rd) & ~s1_inr) | ((s2_wr | s2_rd) & ~s2_inr)) oor_d = 1'b1;
        if (s1_wr && s2_wr && (s1_address == s2_address) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oor_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            oor_q <= oor_d;
            cnt_q <= cnt_d;
        end
    end

    assign oor_error       = oor_q;
    assign collision_count = cnt_q;

`ifdef DESCRIPTOR_RAM_DP_OUTREG_EN
    logic                  o1_vld_q, o2_vld_q;
    logic [DATA_WIDTH-1:0] o1_data_q, o2_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o1_vld_q  <= 1'b0;
            o2_vld_q  <= 1'b0;
            o1_data_q <= '0;
            o2_data_q <= '0;
        end else if (clken) begin
            o1_vld_q <= rd1_vld_q;
            o2_vld_q <= rd2_vld_q;
            if (rd1_vld_q) o1_data_q <= rd1_data_q;
            if (rd2_vld_q) o2_data_q <= rd2_data_q;
        end
    end

    assign s1_readdatavalid = o1_vld_q;
    assign s1_readdata      = o1_data_q;
    assign s2_readdatavalid = o2_vld_q;
    assign s2_readdata      = o2_data_q;
`else
    assign s1_readdatavalid = rd1_vld_q;
    assign s1_readdata      = rd1_data_q;
    assign s2_readdatavalid = rd2_vld_q;
    assign s2_readdata      = rd2_data_q;
`endif

endmodule

// File: tb/tb_descriptor_ram_dp.sv
// Bench for descriptor_ram_dp: directed table, corner sequences and random traffic against a queue-based model.
module tb_descriptor_ram_dp;
`ifdef DESCRIPTOR_RAM_DP_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam int DEPTH = 1000;
    localparam int CMAX  = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clken = 1'b0;
    logic [9:0]  s1_address = '0, s2_address = '0;
    logic        s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic        s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
    logic [3:0]  s1_byteenable = '0, s2_byteenable = '0;
    logic [31:0] s1_writedata = '0, s2_writedata = '0;
    logic [31:0] s1_readdata, s2_readdata;
    logic        s1_readdatavalid, s2_readdatavalid;
    logic        oor_error;
    logic [3:0]  collision_count;

    descriptor_ram_dp #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(DEPTH), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .reset(reset), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
        .oor_error(oor_error), .collision_count(collision_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ce;
        bit          c1, rd1, wr1;
        logic [9:0]  a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        bit          c2, rd2, wr2;
        logic [9:0]  a2;
        logic [3:0]  be2;
        logic [31:0] d2;
    } req_t;

    typedef struct {
        req_t        req;
        bit          ev1;
        logic [31:0] ed1;
        bit          ev2;
        logic [31:0] ed2;
        bit          eoor;
        int          ecnt;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    int n_err = 0;
    int n_chk = 0;

    // reference model state
    logic [31:0] m_mem [0:1023];
    resp_t       q1[$], q2[$];
    int          en_cnt = 0;
    bit          m_v1 = 0, m_v2 = 0, m_oor = 0;
    logic [31:0] m_d1 = '0, m_d2 = '0;
    int          m_cnt = 0;

    function automatic req_t idle();
        req_t t;
        t = '{ce: 1'b1, c1: 1'b0, rd1: 1'b0, wr1: 1'b0, a1: '0, be1: '0, d1: '0,
              c2: 1'b0, rd2: 1'b0, wr2: 1'b0, a2: '0, be2: '0, d2: '0};
        return t;
    endfunction

    function automatic req_t p1(input req_t r, input bit rd, input bit wr, input int a,
                                input logic [3:0] be, input logic [31:0] d);
        req_t t = r;
        t.c1 = 1'b1; t.rd1 = rd; t.wr1 = wr; t.a1 = 10'(a); t.be1 = be; t.d1 = d;
        return t;
    endfunction

    function automatic req_t p2(input req_t r, input bit rd, input bit wr, input int a,
                                input logic [3:0] be, input logic [31:0] d);
        req_t t = r;
        t.c2 = 1'b1; t.rd2 = rd; t.wr2 = wr; t.a2 = 10'(a); t.be2 = be; t.d2 = d;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input req_t r);
        clken         = r.ce;
        s1_chipselect = r.c1; s1_read = r.rd1; s1_write = r.wr1;
        s1_address    = r.a1; s1_byteenable = r.be1; s1_writedata = r.d1;
        s2_chipselect = r.c2; s2_read = r.rd2; s2_write = r.wr2;
        s2_address    = r.a2; s2_byteenable = r.be2; s2_writedata = r.d2;
    endtask

    task automatic model_reset();
        q1.delete(); q2.delete();
        m_v1 = 0; m_v2 = 0; m_d1 = '0; m_d2 = '0; m_oor = 0; m_cnt = 0;
    endtask

    // One rising edge of the specified behaviour: reads see pre-write contents,
    // responses leave in order L enabled edges after acceptance (L=1: same edge).
    task automatic model_step(input req_t r);
        bit    ar1, aw1, ar2, aw2;
        resp_t t;
        if (reset || !r.ce) return;
        en_cnt++;
        ar1 = r.c1 && r.rd1 && !r.wr1;
        aw1 = r.c1 && r.wr1;
        ar2 = r.c2 && r.rd2 && !r.wr2;
        aw2 = r.c2 && r.wr2;
        if (ar1) q1.push_back('{(int'(r.a1) < DEPTH) ? m_mem[r.a1] : 32'h0, en_cnt + L - 1});
        if (ar2) q2.push_back('{(int'(r.a2) < DEPTH) ? m_mem[r.a2] : 32'h0, en_cnt + L - 1});
        m_v1 = 0;
        if (q1.size() > 0 && q1[0].due == en_cnt) begin
            t = q1.pop_front(); m_v1 = 1; m_d1 = t.data;
        end
        m_v2 = 0;
        if (q2.size() > 0 && q2[0].due == en_cnt) begin
            t = q2.pop_front(); m_v2 = 1; m_d2 = t.data;
        end
        if (aw2 && int'(r.a2) < DEPTH)
            for (int b = 0; b < 4; b++) if (r.be2[b]) m_mem[r.a2][b*8 +: 8] = r.d2[b*8 +: 8];
        if (aw1 && int'(r.a1) < DEPTH)
            for (int b = 0; b < 4; b++) if (r.be1[b]) m_mem[r.a1][b*8 +: 8] = r.d1[b*8 +: 8];
        if (aw1 && aw2 && r.a1 == r.a2 && m_cnt < CMAX) m_cnt++;
        if (((ar1 || aw1) && int'(r.a1) >= DEPTH) || ((ar2 || aw2) && int'(r.a2) >= DEPTH)) m_oor = 1;
    endtask

    task automatic compare_model();
        chk("s1_readdatavalid", 32'(s1_readdatavalid), 32'(m_v1));
        chk("s1_readdata", s1_readdata, m_d1);
        chk("s2_readdatavalid", 32'(s2_readdatavalid), 32'(m_v2));
        chk("s2_readdata", s2_readdata, m_d2);
        chk("oor_error", 32'(oor_error), 32'(m_oor));
        chk("collision_count", 32'(collision_count), 32'(m_cnt));
    endtask

    task automatic cycle(input req_t r);
        drive(r);
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        compare_model();
    endtask

    vec_t        tbl[14];
    req_t        r;
    logic [31:0] got[$];
    int          strobes;

    initial begin
        drive(idle());
        clken = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_model();
        chk("reset_s1_readdata", s1_readdata, 32'h0);
        chk("reset_cnt", 32'(collision_count), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) cycle(p1(idle(), 0, 1, i, 4'hF, 32'h0));

        tbl[0]  = '{p1(idle(), 0, 1, 5, 4'hF, 32'hDEADBEEF), 0, 32'h0, 0, 32'h0, 0, 0};
        tbl[1]  = '{p2(idle(), 1, 0, 5, 4'h0, 32'h0), 0, 32'h0, 1, 32'hDEADBEEF, 0, 0};
        tbl[2]  = '{p1(idle(), 0, 1, 7, 4'hF, 32'h11223344), 0, 32'h0, 0, 32'hDEADBEEF, 0, 0};
        tbl[3]  = '{p2(p1(idle(), 0, 1, 7, 4'h3, 32'hAAAAAAAA), 0, 1, 7, 4'h6, 32'hBBBBBBBB),
                    0, 32'h0, 0, 32'hDEADBEEF, 0, 1};
        tbl[4]  = '{p1(idle(), 1, 0, 7, 4'h0, 32'h0), 1, 32'h11BBAAAA, 0, 32'hDEADBEEF, 0, 1};
        tbl[5]  = '{p2(p1(idle(), 1, 0, 9, 4'h0, 32'h0), 0, 1, 9, 4'hF, 32'h00000055),
                    1, 32'h0, 0, 32'hDEADBEEF, 0, 1};
        tbl[6]  = '{p1(idle(), 1, 0, 9, 4'h0, 32'h0), 1, 32'h55, 0, 32'hDEADBEEF, 0, 1};
        tbl[7]  = '{p1(idle(), 0, 1, 1000, 4'hF, 32'h12345678), 0, 32'h55, 0, 32'hDEADBEEF, 1, 1};
        tbl[8]  = '{p1(idle(), 1, 0, 1000, 4'h0, 32'h0), 1, 32'h0, 0, 32'hDEADBEEF, 1, 1};
        tbl[9]  = '{p1(idle(), 1, 0, 0, 4'h0, 32'h0), 1, 32'h0, 0, 32'hDEADBEEF, 1, 1};
        tbl[10] = '{p1(idle(), 1, 1, 5, 4'hF, 32'hFFFFFFFF), 0, 32'h0, 0, 32'hDEADBEEF, 1, 1};
        tbl[11] = '{p2(idle(), 1, 0, 5, 4'h0, 32'h0), 0, 32'h0, 1, 32'hFFFFFFFF, 1, 1};
        tbl[12] = '{p2(idle(), 0, 1, 5, 4'h9, 32'h0), 0, 32'h0, 0, 32'hFFFFFFFF, 1, 1};
        tbl[13] = '{p1(idle(), 1, 0, 5, 4'h0, 32'h0), 1, 32'h00FFFF00, 0, 32'hFFFFFFFF, 1, 1};

        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].req);
            repeat (L - 1) cycle(idle());
            chk($sformatf("vec%0d_s1_valid", i), 32'(s1_readdatavalid), 32'(tbl[i].ev1));
            chk($sformatf("vec%0d_s1_data", i), s1_readdata, tbl[i].ed1);
            chk($sformatf("vec%0d_s2_valid", i), 32'(s2_readdatavalid), 32'(tbl[i].ev2));
            chk($sformatf("vec%0d_s2_data", i), s2_readdata, tbl[i].ed2);
            chk($sformatf("vec%0d_oor", i), 32'(oor_error), 32'(tbl[i].eoor));
            chk($sformatf("vec%0d_cnt", i), 32'(collision_count), 32'(tbl[i].ecnt));
        end

        // back-to-back s2 reads with clken dropped for two cycles mid-stream
        for (int i = 0; i < 4; i++) cycle(p1(idle(), 0, 1, i, 4'hF, 32'hA0 + 32'(i)));
        for (int i = 0; i < 10; i++) begin
            case (i)
                0, 1:    r = p2(idle(), 1, 0, i, 4'h0, 32'h0);
                2, 3:    begin r = p2(idle(), 1, 0, 30, 4'h0, 32'h0); r.ce = 1'b0; end
                4, 5:    r = p2(idle(), 1, 0, i - 2, 4'h0, 32'h0);
                default: r = idle();
            endcase
            cycle(r);
            if (r.ce && s2_readdatavalid) got.push_back(s2_readdata);
        end
        chk("stream_strobes", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk($sformatf("stream_data%0d", i), got[i], 32'hA0 + 32'(i));
        end

        // reset with reads in flight
        cycle(p2(p1(idle(), 1, 0, 1, 4'h0, 32'h0), 1, 0, 2, 4'h0, 32'h0));
        r = p2(p1(idle(), 1, 0, 0, 4'h0, 32'h0), 1, 0, 3, 4'h0, 32'h0);
        drive(r);
        @(posedge clk);
        model_step(r);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_async_s1_valid", 32'(s1_readdatavalid), 32'h0);
        chk("rst_async_s1_data", s1_readdata, 32'h0);
        chk("rst_async_s2_valid", 32'(s2_readdatavalid), 32'h0);
        chk("rst_async_s2_data", s2_readdata, 32'h0);
        chk("rst_async_oor", 32'(oor_error), 32'h0);
        chk("rst_async_cnt", 32'(collision_count), 32'h0);
        drive(idle());
        repeat (2) begin
            @(negedge clk);
            compare_model();
        end
        reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(idle());
            if (s1_readdatavalid || s2_readdatavalid) strobes++;
        end
        chk("post_reset_strobes", 32'(strobes), 32'h0);

        // collision counter saturation: 2^4+3 dual writes to one address
        for (int i = 0; i < 19; i++) begin
            cycle(p2(p1(idle(), 0, 1, 20, 4'($urandom), $urandom), 0, 1, 20, 4'($urandom), $urandom));
            if (i == 13) chk("cnt_at_14", 32'(collision_count), 32'd14);
        end
        chk("cnt_saturated", 32'(collision_count), 32'd15);
        cycle(p1(idle(), 1, 0, 20, 4'h0, 32'h0));
        repeat (L - 1) cycle(idle());

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = idle();
            r.ce = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) != 0)
                r = p1(r, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 15) == 0) ? 1000 + int'($urandom_range(0, 23)) : int'($urandom_range(0, 31)),
                       4'($urandom), $urandom);
            if ($urandom_range(0, 3) != 0)
                r = p2(r, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 15) == 0) ? 1000 + int'($urandom_range(0, 23)) : int'($urandom_range(0, 31)),
                       4'($urandom), $urandom);
            cycle(r);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
